pc_flow_ctrl: RTL and testbench

Sequencer for program-counter updates in the multicycle core. It accepts one PC-update request at a time from the main control unit and drives the PC source mux select, the PC and EPC write strobes and the exception-vector memory read. It sits between the main control FSM and the PC/EPC registers. The exception entry sequence is multi-cycle, so the main FSM stalls on `busy`.

---
 rtl/pc_flow_if.sv | 29 ++
 rtl/pc_flow_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_flow_if.sv
// Handshake bundle between the main control FSM (master) and the PC update
// sequencer (slave): request fields in, PC/EPC strobes and status out.
interface pc_flow_if;
  logic       req_valid;
  logic [2:0] req_kind;
  logic       br_taken;
  logic [1:0] exc_code;
  logic [2:0] pc_source;
  logic       pc_write;
  logic       epc_write;
  logic       vec_rd;
  logic [7:0] vec_addr;
  logic       busy;
  logic       done;
  logic       in_handler;
  logic       halted;

  modport master (
    output req_valid, req_kind, br_taken, exc_code,
    input  pc_source, pc_write, epc_write, vec_rd, vec_addr,
    input  busy, done, in_handler, halted
  );

  modport slave (
    input  req_valid, req_kind, br_taken, exc_code,
    output pc_source, pc_write, epc_write, vec_rd, vec_addr,
    output busy, done, in_handler, halted
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// PC-update sequencer: one request at a time, multi-cycle exception entry.
// Optional macro PC_NESTED_EXC_EN lets an exception inside a handler re-enter instead of halting.
module pc_flow_ctrl #(
  parameter int         MEM_LAT  = 2,
  parameter logic [7:0] VEC_BASE = 8'd253
) (
  input  logic     clk,
  input  logic     reset,
  pc_flow_if.slave fc
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  localparam logic [2:0] K_SEQ    = 3'b000;
  localparam logic [2:0] K_BRANCH = 3'b001;
  localparam logic [2:0] K_JUMP   = 3'b010;
  localparam logic [2:0] K_JR     = 3'b011;
  localparam logic [2:0] K_RTE    = 3'b100;
  localparam logic [2:0] K_EXC    = 3'b101;

  localparam logic [2:0] PS_PC     = 3'b000;
  localparam logic [2:0] PS_ALU    = 3'b001;
  localparam logic [2:0] PS_EPC    = 3'b010;
  localparam logic [2:0] PS_MDR    = 3'b011;
  localparam logic [2:0] PS_ALUOUT = 3'b100;

`ifdef PC_NESTED_EXC_EN
  localparam logic NESTED_OK = 1'b1;
`else
  localparam logic NESTED_OK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC     = 3'd1,
    S_EXC_EPC  = 3'd2,
    S_EXC_WAIT = 3'd3,
    S_EXC_LOAD = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    pc_source_r;
  logic          pc_write_r;
  logic          epc_write_r;
  logic          vec_rd_r;
  logic [7:0]    vec_addr_r;
  logic          busy_r;
  logic          done_r;
  logic          in_handler_r;
  logic          halted_r;

  // Reserved code 11 shares the invalid-opcode vector.
  function automatic logic [7:0] vec_offset(input logic [1:0] code);
    logic [7:0] off;
    case (code)
      2'b01:   off = 8'd1;
      2'b10:   off = 8'd2;
      default: off = 8'd0;
    endcase
    return off;
  endfunction

  assign fc.pc_source  = pc_source_r;
  assign fc.pc_write   = pc_write_r;
  assign fc.epc_write  = epc_write_r;
  assign fc.vec_rd     = vec_rd_r;
  assign fc.vec_addr   = vec_addr_r;
  assign fc.busy       = busy_r;
  assign fc.done       = done_r;
  assign fc.in_handler = in_handler_r;
  assign fc.halted     = halted_r;

  // Sequencer state, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      pc_source_r  <= PS_PC;
      pc_write_r   <= 1'b0;
      epc_write_r  <= 1'b0;
      vec_rd_r     <= 1'b0;
      vec_addr_r   <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      in_handler_r <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      pc_write_r  <= 1'b0;
      epc_write_r <= 1'b0;
      vec_rd_r    <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          pc_source_r <= PS_PC;
          busy_r      <= 1'b0;
          if (fc.req_valid) begin
            case (fc.req_kind)
              K_SEQ, K_JR: begin
                state_r     <= S_EXEC;
                pc_source_r <= PS_ALU;
                pc_write_r  <= 1'b1;
                done_r      <= 1'b1;
                busy_r      <= 1'b1;
              end
              K_BRANCH: begin
                state_r     <= S_EXEC;
                pc_source_r <= PS_ALUOUT;
                pc_write_r  <= fc.br_taken;
                done_r      <= 1'b1;
                busy_r      <= 1'b1;
              end
              K_JUMP: begin
                state_r     <= S_EXEC;
                pc_source_r <= PS_ALUOUT;
                pc_write_r  <= 1'b1;
                done_r      <= 1'b1;
                busy_r      <= 1'b1;
              end
              K_RTE: begin
                state_r     <= S_EXEC;
                pc_source_r <= PS_EPC;
                pc_write_r  <= 1'b1;
                done_r      <= 1'b1;
                busy_r      <= 1'b1;
              end
              K_EXC: begin
                busy_r <= 1'b1;
                if (in_handler_r && !NESTED_OK) begin
                  state_r  <= S_HALT;
                  halted_r <= 1'b1;
                end else begin
                  state_r     <= S_EXC_EPC;
                  epc_write_r <= 1'b1;
                  vec_rd_r    <= 1'b1;
                  vec_addr_r  <= VEC_BASE + vec_offset(fc.exc_code);
                end
              end
              default: state_r <= S_IDLE;
            endcase
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          state_r     <= S_IDLE;
          pc_source_r <= PS_PC;
          busy_r      <= 1'b0;
          // An RTE is the only EXEC kind that selects EPC.
          if (pc_source_r == PS_EPC) begin
            in_handler_r <= 1'b0;
          end else begin
            in_handler_r <= in_handler_r;
          end
        end
        S_EXC_EPC: begin
          state_r     <= S_EXC_WAIT;
          cnt_r       <= CNT_LOAD;
          pc_source_r <= PS_PC;
        end
        S_EXC_WAIT: begin
          if (cnt_r == '0) begin
            state_r     <= S_EXC_LOAD;
            pc_source_r <= PS_MDR;
            pc_write_r  <= 1'b1;
            done_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_EXC_LOAD: begin
          state_r      <= S_IDLE;
          cnt_r        <= '0;
          pc_source_r  <= PS_PC;
          busy_r       <= 1'b0;
          in_handler_r <= 1'b1;
        end
        S_HALT: begin
          state_r     <= S_HALT;
          pc_source_r <= PS_PC;
          busy_r      <= 1'b1;
          halted_r    <= 1'b1;
        end
        default: begin
          state_r      <= S_IDLE;
          cnt_r        <= '0;
          pc_source_r  <= PS_PC;
          vec_addr_r   <= 8'd0;
          busy_r       <= 1'b0;
          in_handler_r <= 1'b0;
          halted_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed vector table, then random requests checked
// against a per-request cycle-schedule model.
module tb_pc_flow_ctrl;

  localparam int         MEM_LAT  = 2;
  localparam logic [7:0] VEC_BASE = 8'd253;

  localparam logic       H = 1'b1;
  localparam logic       L = 1'b0;
  localparam logic [2:0] K_SEQ  = 3'd0;
  localparam logic [2:0] K_BR   = 3'd1;
  localparam logic [2:0] K_JUMP = 3'd2;
  localparam logic [2:0] K_JR   = 3'd3;
  localparam logic [2:0] K_RTE  = 3'd4;
  localparam logic [2:0] K_EXC  = 3'd5;

`ifdef PC_NESTED_EXC_EN
  localparam logic NESTED = 1'b1;
`else
  localparam logic NESTED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_flow_if bus();

  pc_flow_ctrl #(.MEM_LAT(MEM_LAT), .VEC_BASE(VEC_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .fc    (bus)
  );

  typedef struct packed {
    logic [2:0] ps;
    logic       pw;
    logic       ew;
    logic       vr;
    logic       dn;
    logic       bz;
    logic       ih;
    logic       ht;
    logic [7:0] va;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       rv;
    logic [2:0] kind;
    logic       bt;
    logic [1:0] code;
    outs_t      exp;
    logic       cva;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic outs_t mk(input logic [2:0] ps, input logic pw, input logic ew,
                               input logic vr, input logic dn, input logic bz,
                               input logic ih, input logic ht, input logic [7:0] va);
    outs_t o;
    o.ps = ps; o.pw = pw; o.ew = ew; o.vr = vr; o.dn = dn;
    o.bz = bz; o.ih = ih; o.ht = ht; o.va = va;
    return o;
  endfunction

  function automatic outs_t idle(input logic ih);
    return mk(3'd0, L, L, L, L, L, ih, L, 8'd0);
  endfunction

  function automatic void add(input logic r, input logic rv, input logic [2:0] k,
                              input logic bt, input logic [1:0] c, input outs_t e,
                              input logic cva);
    vec_t v;
    v.rst = r; v.rv = rv; v.kind = k; v.bt = bt; v.code = c; v.exp = e; v.cva = cva;
    tbl.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic rv, input logic [2:0] k,
                       input logic bt, input logic [1:0] c);
    reset         = r;
    bus.req_valid = rv;
    bus.req_kind  = k;
    bus.br_taken  = bt;
    bus.exc_code  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input outs_t e, input logic cva);
    outs_t a;
    a = {bus.pc_source, bus.pc_write, bus.epc_write, bus.vec_rd, bus.done,
         bus.busy, bus.in_handler, bus.halted, bus.vec_addr};
    if (!cva) begin
      a.va = 8'd0;
      e.va = 8'd0;
    end
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got ps=%0d pw=%b ew=%b vr=%b dn=%b bz=%b ih=%b ht=%b va=%0d, required ps=%0d pw=%b ew=%b vr=%b dn=%b bz=%b ih=%b ht=%b va=%0d",
               nm, idx, a.ps, a.pw, a.ew, a.vr, a.dn, a.bz, a.ih, a.ht, a.va,
               e.ps, e.pw, e.ew, e.vr, e.dn, e.bz, e.ih, e.ht, e.va);
    end
  endtask

  // Reference model: an accepted request expands into the list of cycles it occupies.
  outs_t mq[$];
  logic  mcv[$];
  int    mact[$];
  logic  m_ih   = 1'b0;
  logic  m_halt = 1'b0;
  logic  m_busy = 1'b0;
  int    m_pend = 0;

  function automatic void push(input outs_t o, input logic cv, input int act);
    mq.push_back(o);
    mcv.push_back(cv);
    mact.push_back(act);
  endfunction

  function automatic void plan(input logic [2:0] k, input logic bt, input logic [1:0] c);
    logic [7:0] va;
    va = VEC_BASE + ((c == 2'd3) ? 8'd0 : {6'd0, c});
    case (k)
      K_SEQ, K_JR: push(mk(3'd1, H, L, L, H, H, L, L, 8'd0), L, 0);
      K_BR:        push(mk(3'd4, bt, L, L, H, H, L, L, 8'd0), L, 0);
      K_JUMP:      push(mk(3'd4, H, L, L, H, H, L, L, 8'd0), L, 0);
      K_RTE:       push(mk(3'd2, H, L, L, H, H, L, L, 8'd0), L, 2);
      K_EXC: begin
        push(mk(3'd0, L, H, H, L, H, L, L, va), H, 0);
        for (int i = 0; i < MEM_LAT; i++) push(mk(3'd0, L, L, L, L, H, L, L, va), H, 0);
        push(mk(3'd3, H, L, L, H, H, L, L, 8'd0), L, 1);
      end
      default: ;
    endcase
  endfunction

  function automatic void model_step(input logic r, input logic rv, input logic [2:0] k,
                                     input logic bt, input logic [1:0] c,
                                     output outs_t e, output logic cva);
    if (r) begin
      mq.delete(); mcv.delete(); mact.delete();
      m_ih = L; m_halt = L; m_busy = L; m_pend = 0;
      e = mk(3'd0, L, L, L, L, L, L, L, 8'd0);
      cva = H;
      return;
    end
    if (m_pend == 1) m_ih = H;
    else if (m_pend == 2) m_ih = L;
    m_pend = 0;
    if (!m_halt && !m_busy && rv && k <= K_EXC) begin
      if (k == K_EXC && m_ih && !NESTED) m_halt = H;
      else plan(k, bt, c);
    end
    if (m_halt) begin
      e = mk(3'd0, L, L, L, L, H, m_ih, H, 8'd0);
      cva = L;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      cva = mcv.pop_front();
      m_pend = mact.pop_front();
      e.ih = m_ih;
    end else begin
      e = idle(m_ih);
      cva = L;
    end
    m_busy = e.bz;
  endfunction

  initial begin
    outs_t e;
    logic  cva, r, rv, bt;
    logic [2:0] k;
    logic [1:0] c;

    // Directed table: inputs applied at an edge, outputs expected in the following cycle.
    add(H, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, L, L, L, 8'd0), H);
    add(L, H, K_SEQ, L, 2'd0, mk(3'd1, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, K_BR,  L, 2'd0, mk(3'd4, L, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, K_BR,  H, 2'd0, mk(3'd4, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, K_EXC, L, 2'd2, mk(3'd0, L, H, H, L, H, L, L, 8'd255), H);
    add(L, H, K_JUMP, L, 2'd0, mk(3'd0, L, L, L, L, H, L, L, 8'd255), H);
    add(L, H, K_JUMP, L, 2'd0, mk(3'd0, L, L, L, L, H, L, L, 8'd255), H);
    add(L, H, K_JUMP, L, 2'd0, mk(3'd3, H, L, L, H, H, L, L, 8'd0), L);
    add(L, H, K_JUMP, L, 2'd0, idle(H), L);
    add(L, H, K_JUMP, L, 2'd0, mk(3'd4, H, L, L, H, H, H, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(H), L);
    add(L, H, K_RTE, L, 2'd0, mk(3'd2, H, L, L, H, H, H, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, K_JR,  L, 2'd0, mk(3'd1, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, 3'd6,  L, 2'd0, idle(L), L);
    add(L, H, 3'd7,  L, 2'd0, idle(L), L);
    add(L, H, K_EXC, L, 2'd3, mk(3'd0, L, H, H, L, H, L, L, 8'd253), H);
    add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, L, L, 8'd253), H);
    add(H, H, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, L, L, L, 8'd0), H);
    add(L, H, K_SEQ, L, 2'd0, mk(3'd1, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);
    add(L, H, K_EXC, L, 2'd1, mk(3'd0, L, H, H, L, H, L, L, 8'd254), H);
    add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, L, L, 8'd254), H);
    add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, L, L, 8'd254), H);
    add(L, L, K_SEQ, L, 2'd0, mk(3'd3, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(H), L);
    // Second exception while the handler is active.
    if (NESTED) begin
      add(L, H, K_EXC, L, 2'd0, mk(3'd0, L, H, H, L, H, H, L, 8'd253), H);
      add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, H, L, 8'd253), H);
      add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, H, L, 8'd253), H);
      add(L, L, K_SEQ, L, 2'd0, mk(3'd3, H, L, L, H, H, H, L, 8'd0), L);
      add(L, L, K_SEQ, L, 2'd0, idle(H), L);
    end else begin
      add(L, H, K_EXC, L, 2'd0, mk(3'd0, L, L, L, L, H, H, H, 8'd0), L);
      add(L, H, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, H, H, 8'd0), L);
      add(L, H, K_RTE, L, 2'd0, mk(3'd0, L, L, L, L, H, H, H, 8'd0), L);
      add(L, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, H, H, H, 8'd0), L);
    end
    add(H, L, K_SEQ, L, 2'd0, mk(3'd0, L, L, L, L, L, L, L, 8'd0), H);
    add(L, H, K_SEQ, L, 2'd0, mk(3'd1, H, L, L, H, H, L, L, 8'd0), L);
    add(L, L, K_SEQ, L, 2'd0, idle(L), L);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].rv, tbl[i].kind, tbl[i].bt, tbl[i].code);
      check("tbl", i, tbl[i].exp, tbl[i].cva);
    end

    // Random traffic against the schedule model.
    for (int i = 0; i < 3000; i++) begin
      r  = (i == 0) || ($urandom_range(0, 39) == 0);
      rv = $urandom_range(0, 1) == 1;
      k  = 3'($urandom_range(0, 7));
      bt = $urandom_range(0, 1) == 1;
      c  = 2'($urandom_range(0, 3));
      model_step(r, rv, k, bt, c, e, cva);
      apply(r, rv, k, bt, c);
      check("rnd", i, e, cva);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
